// File: rtl/aes_encrypt_serial32_pkg.sv
// Shared definitions for the column-serial AES-128 encryptor:
// FSM encoding, round/word constants and GF(2^8) helpers, including the S-box.
package aes_encrypt_serial32_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARK0 = 2'd1,
    RND  = 2'd2,
    DONE = 2'd3
  } aes_fsm_e;

  localparam logic [3:0] NR        = 4'd10;
  localparam int         NK        = 4;
  localparam logic [5:0] LAST_WORD = 6'd43;

  // Multiply by x in GF(2^8) modulo the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // General GF(2^8) product, shift-and-add over the bits of b.
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] acc;
    logic [7:0] aa;
    acc = 8'h00;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = xtime(aa);
    end
    return acc;
  endfunction

  // S-box: multiplicative inverse as b^254 (0 maps to 0), then the affine map.
  // The exponent chain is 254 = 240 + 12 + 2.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, inv;
    x2   = gfMul(b, b);
    x3   = gfMul(x2, b);
    x6   = gfMul(x3, x3);
    x12  = gfMul(x6, x6);
    x15  = gfMul(x12, x3);
    x30  = gfMul(x15, x15);
    x60  = gfMul(x30, x30);
    x120 = gfMul(x60, x60);
    x240 = gfMul(x120, x120);
    inv  = gfMul(gfMul(x240, x12), x2);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_encrypt_serial32_mixcol.sv
// MixColumns for a single 32-bit column; row 0 is the most significant byte.
module aes_encrypt_serial32_mixcol
  import aes_encrypt_serial32_pkg::*;
(
  input  logic [31:0] col_i,
  output logic [31:0] col_o
);

  logic [7:0] a0, a1, a2, a3;

  assign a0 = col_i[31:24];
  assign a1 = col_i[23:16];
  assign a2 = col_i[15:8];
  assign a3 = col_i[7:0];

  // Fixed matrix {02 03 01 01} rotated per row, with 03*a = xtime(a)^a.
  always_comb begin
    col_o = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  end

endmodule

// File: rtl/aes_encrypt_serial32.sv
// AES-128 encryption, one column per cycle, fed by an on-the-fly key expander.
// Round 0 XORs key words in place; rounds 1..10 build new columns into a shadow
// so ShiftRows always reads the unmodified state, committing on column 3.
module aes_encrypt_serial32
  import aes_encrypt_serial32_pkg::*;
#(
  parameter bit CHECK_WORD_ADDR = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] pt_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] ct_out,
  output logic         ks_start,
  output logic [127:0] ks_key,
  output logic         ks_next,
  input  logic [31:0]  ks_round_key,
  input  logic [5:0]   ks_word_addr,
  input  logic         ks_ready,
  output logic         err
);

  aes_fsm_e          fsm_q, fsm_d;
  logic [0:3][31:0]  state_q, state_d;
  logic [0:2][31:0]  shadow_q, shadow_d;
  logic [3:0]        rnd_q, rnd_d;
  logic [1:0]        col_q, col_d;
  logic              err_q, err_d;

  logic              acceptBlk;
  logic              procCycle;
  logic              lastWord;
  logic [31:0]       shiftCol;
  logic [31:0]       subCol;
  logic [31:0]       mixCol;
  logic [31:0]       roundCol;
  logic [31:0]       arkCol;

  assign acceptBlk = in_valid && (fsm_q == IDLE);
  assign procCycle = ((fsm_q == ARK0) || (fsm_q == RND)) && ks_ready;
  assign lastWord  = ({rnd_q, col_q} == LAST_WORD);
  assign ks_start  = acceptBlk;
  assign ks_key    = key_in;
  assign err       = err_q;

  // ShiftRows for the column being built: row r comes from column (col+r) mod 4.
  assign shiftCol = {state_q[col_q][31:24],
                     state_q[col_q + 2'd1][23:16],
                     state_q[col_q + 2'd2][15:8],
                     state_q[col_q + 2'd3][7:0]};

  assign subCol = {sbox(shiftCol[31:24]), sbox(shiftCol[23:16]),
                   sbox(shiftCol[15:8]),  sbox(shiftCol[7:0])};

  aes_encrypt_serial32_mixcol u_mixcol (
    .col_i (subCol),
    .col_o (mixCol)
  );

  assign roundCol = ((rnd_q == NR) ? subCol : mixCol) ^ ks_round_key;
  assign arkCol   = state_q[col_q] ^ ks_round_key;

  // State register and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q    <= IDLE;
      state_q  <= '0;
      shadow_q <= '0;
      rnd_q    <= '0;
      col_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      fsm_q    <= fsm_d;
      state_q  <= state_d;
      shadow_q <= shadow_d;
      rnd_q    <= rnd_d;
      col_q    <= col_d;
      err_q    <= err_d;
    end
  end

  // Next FSM state; a stalled expander simply keeps ARK0/RND where they are.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (in_valid) fsm_d = ARK0;
      ARK0:    if (ks_ready && (col_q == 2'd3)) fsm_d = RND;
      RND:     if (ks_ready && lastWord) fsm_d = DONE;
      DONE:    if (out_ready) fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  // Next datapath values: load on acceptance, one column per non-stalled cycle.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    rnd_d    = rnd_q;
    col_d    = col_q;
    err_d    = err_q;
    if (acceptBlk) begin
      state_d = pt_in;
      rnd_d   = '0;
      col_d   = '0;
      err_d   = 1'b0;
    end else if (procCycle) begin
      col_d = col_q + 2'd1;
      if (fsm_q == ARK0) begin
        state_d[col_q] = arkCol;
      end else begin
        case (col_q)
          2'd0:    shadow_d[0] = roundCol;
          2'd1:    shadow_d[1] = roundCol;
          2'd2:    shadow_d[2] = roundCol;
          default: state_d     = {shadow_q, roundCol};
        endcase
      end
      if (col_q == 2'd3) rnd_d = (rnd_q == NR) ? 4'd0 : rnd_q + 4'd1;
      if (CHECK_WORD_ADDR && (ks_word_addr != {rnd_q, col_q})) err_d = 1'b1;
    end
  end

  // Handshake and expander-control outputs decoded from the FSM state.
  always_comb begin
    in_ready  = (fsm_q == IDLE);
    out_valid = (fsm_q == DONE);
    ks_next   = procCycle && !lastWord;
    ct_out    = (fsm_q == DONE) ? state_q : '0;
  end

endmodule
